// File: rtl/dmem_pkg.sv
// dmem_pkg: shared width, default latency and FSM state type for the data-memory responder
package dmem_pkg;
    localparam int DATA_W = 16;
    localparam int LATENCY_DEF = 4;
    typedef enum logic {CLEAR, READY} state_t;
endpackage

// File: rtl/dmem_rd_pipe.sv
// dmem_rd_pipe: LATENCY-stage load-return shift register; data/addr hold when no load is in a stage
module dmem_rd_pipe
    import dmem_pkg::*;
#(
    parameter int LATENCY = LATENCY_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    input  logic [15:0]       ld_addr,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [15:0]       rsp_addr
);
    logic [LATENCY-1:0] v;
    logic [DATA_W-1:0]  d [LATENCY];
    logic [15:0]        a [LATENCY];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                d[i] <= '0;
                a[i] <= '0;
            end
        end else begin
            v[0] <= ld_valid;
            if (ld_valid) begin
                d[0] <= ld_data;
                a[0] <= ld_addr;
            end
            for (int i = 1; i < LATENCY; i++) begin
                v[i] <= v[i-1];
                if (v[i-1]) begin
                    d[i] <= d[i-1];
                    a[i] <= a[i-1];
                end
            end
        end
    end
    assign rsp_valid = v[LATENCY-1];
    assign rsp_rdata = d[LATENCY-1];
    assign rsp_addr  = a[LATENCY-1];
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: word-addressed 16-bit data memory with zero-fill sweep after reset
// and fixed-latency, fully pipelined load responses
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W         = 10,
    parameter int LATENCY        = LATENCY_DEF,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_wr,
    input  logic [15:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [15:0]       rsp_addr
);
    localparam int DEPTH = 2 ** ADDR_W;
    state_t state, state_nxt;
    logic [ADDR_W-1:0] clr_idx;
    logic [ADDR_W-1:0] widx;
    logic [DATA_W-1:0] mem [DEPTH];
    logic accept;
    assign widx   = req_addr[ADDR_W:1];
    assign accept = req_valid & req_ready;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= CLEAR_ON_RESET ? CLEAR : READY;
        else     state <= state_nxt;
    end
    always_comb begin
        state_nxt = (state == CLEAR && &clr_idx) ? READY : state;
    end
    // rst gates ready so it drops at once even when reset lands in READY
    always_comb begin
        req_ready = (state == READY) && !rst;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                 clr_idx <= '0;
        else if (state == CLEAR) clr_idx <= clr_idx + ADDR_W'(1);
    end
    // array has no reset: only the sweep zeroes it
    always_ff @(posedge clk) begin
        if (state == CLEAR)        mem[clr_idx] <= '0;
        else if (accept && req_wr) mem[widx] <= req_wdata;
    end
    dmem_rd_pipe #(.LATENCY(LATENCY)) u_rd_pipe (
        .clk       (clk),
        .rst       (rst),
        .ld_valid  (accept & ~req_wr),
        .ld_data   (mem[widx]),
        .ld_addr   (req_addr),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_addr  (rsp_addr)
    );
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed table, reset corner sequences and random traffic
// against a cycle-level memory/queue reference model
module tb_dmem_responder;
    localparam int LAT = 4;
    localparam int WORDS = 16;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic req_valid = 1'b0, req_wr = 1'b0;
    logic [15:0] req_addr = '0, req_wdata = '0;
    logic req_ready, rsp_valid;
    logic [15:0] rsp_rdata, rsp_addr;

    dmem_responder #(.ADDR_W(4), .LATENCY(LAT), .CLEAR_ON_RESET(1'b1)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_addr(rsp_addr)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [15:0] a;
        logic [15:0] d;
    } rsp_t;
    typedef struct {
        logic        v;
        logic        w;
        logic [15:0] a;
        logic [15:0] d;
        logic        ev;
        logic [15:0] ed;
        logic [15:0] ea;
    } vec_t;

    int n_chk = 0, n_fail = 0;
    int cyc = 0, sweep = 0;
    logic [15:0] mem_m [WORDS];
    rsp_t q [$];
    logic [15:0] last_d = '0, last_a = '0;
    vec_t vt [21];

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        sweep = 0;
        last_d = '0;
        last_a = '0;
    endtask

    task automatic step(input logic v, input logic w, input logic [15:0] a, input logic [15:0] d);
        int idx;
        logic ev;
        req_valid = v; req_wr = w; req_addr = a; req_wdata = d;
        @(posedge clk);
        cyc++;
        idx = int'(a[4:1]);
        if (v && sweep >= WORDS) begin
            if (w) mem_m[idx] = d;
            else   q.push_back('{cyc + LAT - 1, a, mem_m[idx]});
        end
        if (sweep < WORDS) begin
            mem_m[sweep] = '0;
            sweep++;
        end
        #1;
        req_valid = 1'b0;
        ev = q.size() > 0 && q[0].due == cyc;
        if (ev) begin
            last_d = q[0].d;
            last_a = q[0].a;
            void'(q.pop_front());
        end
        chk("rsp_valid", {15'b0, rsp_valid}, {15'b0, ev});
        chk("rsp_rdata", rsp_rdata, last_d);
        chk("rsp_addr", rsp_addr, last_a);
        chk("req_ready", {15'b0, req_ready}, {15'b0, sweep >= WORDS});
    endtask

    task automatic check_reset_outputs();
        chk("rst_rsp_valid", {15'b0, rsp_valid}, 16'h0);
        chk("rst_rsp_rdata", rsp_rdata, 16'h0);
        chk("rst_rsp_addr", rsp_addr, 16'h0);
        chk("rst_req_ready", {15'b0, req_ready}, 16'h0);
    endtask

    // reset asserted mid-cycle, held across one edge, released mid-cycle
    task automatic pulse_rst();
        #2 rst = 1'b1;
        #1 model_reset();
        check_reset_outputs();
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic count_sweep(input logic v, input logic w, input logic [15:0] a, input logic [15:0] d);
        int cnt = 0;
        while (req_ready !== 1'b1 && cnt < 40) begin
            step(v, w, a, d);
            cnt++;
        end
        chk("sweep_len", 16'(cnt), 16'd16);
    endtask

    initial begin
        for (int i = 0; i < WORDS; i++) mem_m[i] = '0;
        vt[0]  = '{1'b1, 1'b1, 16'h0006, 16'hBEEF, 1'b0, 16'h0000, 16'h001E};
        vt[1]  = '{1'b1, 1'b0, 16'h0007, 16'h0000, 1'b0, 16'h0000, 16'h001E};
        vt[2]  = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h001E};
        vt[3]  = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h001E};
        vt[4]  = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'hBEEF, 16'h0007};
        vt[5]  = '{1'b1, 1'b1, 16'h0002, 16'h1234, 1'b0, 16'hBEEF, 16'h0007};
        vt[6]  = '{1'b1, 1'b0, 16'h0002, 16'h0000, 1'b0, 16'hBEEF, 16'h0007};
        vt[7]  = '{1'b1, 1'b0, 16'h0022, 16'h0000, 1'b0, 16'hBEEF, 16'h0007};
        vt[8]  = '{1'b1, 1'b0, 16'h0004, 16'h0000, 1'b0, 16'hBEEF, 16'h0007};
        vt[9]  = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h1234, 16'h0002};
        vt[10] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h1234, 16'h0022};
        vt[11] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0000, 16'h0004};
        vt[12] = '{1'b1, 1'b1, 16'h0008, 16'h00AA, 1'b0, 16'h0000, 16'h0004};
        vt[13] = '{1'b1, 1'b0, 16'h0008, 16'h0000, 1'b0, 16'h0000, 16'h0004};
        vt[14] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0004};
        vt[15] = '{1'b1, 1'b1, 16'h0008, 16'h5555, 1'b0, 16'h0000, 16'h0004};
        vt[16] = '{1'b1, 1'b1, 16'h0008, 16'h7777, 1'b1, 16'h00AA, 16'h0008};
        vt[17] = '{1'b1, 1'b0, 16'h0008, 16'h0000, 1'b0, 16'h00AA, 16'h0008};
        vt[18] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h00AA, 16'h0008};
        vt[19] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h00AA, 16'h0008};
        vt[20] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h7777, 16'h0008};

        model_reset();
        repeat (2) @(posedge clk);
        #1 check_reset_outputs();
        rst = 1'b0;

        // power-up sweep, then a load from the top word reads zero
        count_sweep(1'b0, 1'b0, 16'h0000, 16'h0000);
        step(1'b1, 1'b0, 16'h001E, 16'h0000);
        repeat (4) step(1'b0, 1'b0, 16'h0000, 16'h0000);
        chk("load_1e_data", rsp_rdata, 16'h0000);
        chk("load_1e_addr", rsp_addr, 16'h001E);

        for (int i = 0; i < 21; i++) begin
            step(vt[i].v, vt[i].w, vt[i].a, vt[i].d);
            chk($sformatf("vec%0d_valid", i), {15'b0, rsp_valid}, {15'b0, vt[i].ev});
            chk($sformatf("vec%0d_rdata", i), rsp_rdata, vt[i].ed);
            chk($sformatf("vec%0d_addr", i), rsp_addr, vt[i].ea);
        end

        // in-flight loads discarded by reset; second reset lands mid-sweep
        step(1'b1, 1'b1, 16'h0014, 16'hCAFE);
        step(1'b1, 1'b0, 16'h0004, 16'h0000);
        step(1'b1, 1'b0, 16'h0008, 16'h0000);
        step(1'b0, 1'b0, 16'h0000, 16'h0000);
        pulse_rst();
        repeat (5) step(1'b0, 1'b0, 16'h0000, 16'h0000);
        pulse_rst();
        // requests during the sweep are dropped
        count_sweep(1'b1, 1'b1, 16'h000A, 16'hFFFF);
        step(1'b1, 1'b0, 16'h000A, 16'h0000);
        step(1'b1, 1'b0, 16'h0014, 16'h0000);
        repeat (4) step(1'b0, 1'b0, 16'h0000, 16'h0000);
        chk("clear_drop_data", rsp_rdata, 16'h0000);
        chk("clear_drop_addr", rsp_addr, 16'h0014);

        for (int i = 0; i < 400; i++) begin
            if (i == 200) pulse_rst();
            step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 4,
                 16'($urandom), 16'($urandom));
        end
        repeat (LAT + 2) step(1'b0, 1'b0, 16'h0000, 16'h0000);
        chk("queue_drained", 16'(q.size()), 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
